// File: rtl/alu_pkg.sv
// Shared opcode encoding, flag bit positions and opcode legality check for the ALU pipeline.
// Imported by the datapath core and the pipeline wrapper.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_XOR    = 4'b0010,
        OP_SLL    = 4'b0100,
        OP_SRA    = 4'b0101,
        OP_ROR    = 4'b0110,
        OP_PADDSB = 4'b0111,
        OP_LW     = 4'b1000,
        OP_SW     = 4'b1001,
        OP_LLB    = 4'b1010,
        OP_LHB    = 4'b1011
    } op_e;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // 0011 and the whole 11xx block are unassigned.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'b0011) || (op[3:2] == 2'b11);
    endfunction

endpackage

// File: rtl/alu_if.sv
// Operation/result handshake bundle: valid-ready on both the operand side and the result side.
// master drives operands and out_ready; slave (the pipeline) returns in_ready and the registered result.
interface alu_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             illegal;
    logic [2:0]       flags;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, illegal, flags
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, illegal, flags
    );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: saturating add/sub, logic, shifts, lane-wise add, address and byte-load ops.
// Zero latency; no backpressure of its own, the enclosing pipeline decides when outputs are captured.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANE  = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             illegal,
    output logic             z,
    output logic             v,
    output logic             n,
    output logic             upd_z,
    output logic             upd_v,
    output logic             upd_n
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int NLANE = WIDTH / LANE;

    localparam logic [WIDTH-1:0] SMAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SHW:0]     WSIZE = SHW'(0) + (SHW+1)'(WIDTH);

    logic [SHW-1:0]   shamt;
    logic [SHW:0]     rol_amt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] ror_res;
    logic [WIDTH-1:0] lane_sum;
    logic             add_ovf;
    logic             sub_ovf;

    assign shamt   = b[SHW-1:0];
    // A zero rotate shifts left by WIDTH, which yields zero and leaves a unchanged.
    assign rol_amt = WSIZE - {1'b0, shamt};
    assign ror_res = (a >> shamt) | (a << rol_amt);

    assign sum  = a + b;
    assign diff = a - b;

    // Overflow direction always follows the sign of a, for both add and subtract.
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    for (genvar g = 0; g < NLANE; g++) begin : g_lane
        logic [LANE-1:0] la;
        logic [LANE-1:0] lb;
        logic [LANE-1:0] ls;
        logic            lovf;

        assign la   = a[g*LANE +: LANE];
        assign lb   = b[g*LANE +: LANE];
        assign ls   = la + lb;
        assign lovf = (la[LANE-1] == lb[LANE-1]) && (ls[LANE-1] != la[LANE-1]);

        assign lane_sum[g*LANE +: LANE] = !lovf       ? ls :
                                          la[LANE-1]  ? {1'b1, {(LANE-1){1'b0}}} :
                                                        {1'b0, {(LANE-1){1'b1}}};
    end

    always_comb begin
        result = '0;
        v      = 1'b0;
        upd_z  = 1'b0;
        upd_v  = 1'b0;
        upd_n  = 1'b0;
        case (op)
            OP_ADD: begin
                result = add_ovf ? (a[WIDTH-1] ? SMIN : SMAX) : sum;
                v      = add_ovf;
                upd_z  = 1'b1;
                upd_v  = 1'b1;
                upd_n  = 1'b1;
            end
            OP_SUB: begin
                result = sub_ovf ? (a[WIDTH-1] ? SMIN : SMAX) : diff;
                v      = sub_ovf;
                upd_z  = 1'b1;
                upd_v  = 1'b1;
                upd_n  = 1'b1;
            end
            OP_XOR: begin
                result = a ^ b;
                upd_z  = 1'b1;
            end
            OP_SLL: begin
                result = a << shamt;
                upd_z  = 1'b1;
            end
            OP_SRA: begin
                result = $unsigned($signed(a) >>> shamt);
                upd_z  = 1'b1;
            end
            OP_ROR: begin
                result = ror_res;
                upd_z  = 1'b1;
            end
            OP_PADDSB: result = lane_sum;
            OP_LW,
            OP_SW:     result = (a & ~ONE) + b;
            OP_LLB:    result = {a[WIDTH-1:8], b[7:0]};
            OP_LHB:    result = {b[7:0], a[WIDTH-9:0]};
            default:   result = '0;
        endcase
    end

    assign illegal = is_illegal(op);
    assign z       = (result == '0);
    assign n       = result[WIDTH-1];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline (operand stage S1, result stage S2) with {Z,V,N} flags; 2-cycle latency, 1 op/cycle.
// Stalls by holding S2 while out_ready is low; in_ready is combinational from out_ready through both stages.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANE  = 4
) (
    input  logic   clk,
    input  logic   rst,
    alu_if.slave   bus
);

    logic             s1_vld;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [3:0]       s1_op;

    logic             s2_vld;
    logic [WIDTH-1:0] s2_res;
    logic             s2_ill;
    logic [2:0]       flags_q;

    logic             s1_adv;
    logic             s2_adv;

    logic [WIDTH-1:0] core_res;
    logic             core_ill;
    logic             core_z;
    logic             core_v;
    logic             core_n;
    logic             upd_z;
    logic             upd_v;
    logic             upd_n;

    assign s2_adv = bus.out_ready || !s2_vld;
    assign s1_adv = s2_adv || !s1_vld;

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_vld;
    assign bus.result    = s2_res;
    assign bus.illegal   = s2_ill;
    assign bus.flags     = flags_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_op  <= '0;
        end else if (s1_adv) begin
            s1_vld <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a  <= bus.a;
                s1_b  <= bus.b;
                s1_op <= bus.op;
            end
        end
    end

    alu_core #(
        .WIDTH (WIDTH),
        .LANE  (LANE)
    ) u_core (
        .a       (s1_a),
        .b       (s1_b),
        .op      (s1_op),
        .result  (core_res),
        .illegal (core_ill),
        .z       (core_z),
        .v       (core_v),
        .n       (core_n),
        .upd_z   (upd_z),
        .upd_v   (upd_v),
        .upd_n   (upd_n)
    );

    // A bubble moving into S2 drops out_valid but keeps the last result and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld  <= 1'b0;
            s2_res  <= '0;
            s2_ill  <= 1'b0;
            flags_q <= 3'b000;
        end else if (s2_adv) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_res <= core_res;
                s2_ill <= core_ill;
                if (upd_z) flags_q[FLAG_Z] <= core_z;
                if (upd_v) flags_q[FLAG_V] <= core_v;
                if (upd_n) flags_q[FLAG_N] <= core_n;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vector tables at WIDTH 16 and 32, stall/reset sequences, then a random run vs a model.
module tb_alu_pipe;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_if #(.WIDTH(16)) i16();
    alu_if #(.WIDTH(32)) i32();

    alu_pipe #(.WIDTH(16), .LANE(4)) dut16 (.clk(clk), .rst(rst), .bus(i16));
    alu_pipe #(.WIDTH(32), .LANE(8)) dut32 (.clk(clk), .rst(rst), .bus(i32));

    int nvec = 0;
    int nmis = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        ill;
        logic [2:0]  fl;
    } vec16_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        logic [2:0]  fl;
    } vec32_t;

    typedef struct {
        logic [15:0] res;
        logic        ill;
        logic [2:0]  fl;
    } exp_t;

    // Reference model in plain signed integer arithmetic; fl is the {Z,V,N} state before this op.
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic [2:0] fl);
        exp_t   e;
        longint sa, sb, s, wa;
        int     sh;
        logic   zu, vnu, ov;
        logic [15:0] r;
        sa  = a[15] ? longint'(a) - 65536 : longint'(a);
        sb  = b[15] ? longint'(b) - 65536 : longint'(b);
        sh  = int'(b[3:0]);
        r   = 16'h0;
        zu  = 1'b0;
        vnu = 1'b0;
        ov  = 1'b0;
        e.ill = 1'b0;
        case (op)
            4'h0, 4'h1: begin
                s = (op == 4'h0) ? sa + sb : sa - sb;
                if (s > 32767) begin s = 32767; ov = 1'b1; end
                else if (s < -32768) begin s = -32768; ov = 1'b1; end
                r = s[15:0];
                zu = 1'b1;
                vnu = 1'b1;
            end
            4'h2: begin r = a ^ b; zu = 1'b1; end
            4'h4: begin wa = longint'(a) << sh; r = wa[15:0]; zu = 1'b1; end
            4'h5: begin wa = sa >>> sh; r = wa[15:0]; zu = 1'b1; end
            4'h6: begin
                wa = (longint'(a) >> sh) | (longint'(a) << (16 - sh));
                r = wa[15:0];
                zu = 1'b1;
            end
            4'h7: begin
                for (int i = 0; i < 4; i++) begin
                    int x, y, t;
                    x = int'(a[4*i +: 4]); if (x > 7) x -= 16;
                    y = int'(b[4*i +: 4]); if (y > 7) y -= 16;
                    t = x + y;
                    if (t > 7) t = 7;
                    if (t < -8) t = -8;
                    r[4*i +: 4] = t[3:0];
                end
            end
            4'h8, 4'h9: begin wa = longint'(a & 16'hFFFE) + longint'(b); r = wa[15:0]; end
            4'hA: r = {a[15:8], b[7:0]};
            4'hB: r = {b[7:0], a[7:0]};
            default: e.ill = 1'b1;
        endcase
        e.res = r;
        e.fl  = fl;
        if (zu) e.fl[2] = (r == 16'h0);
        if (vnu) begin
            e.fl[1] = ov;
            e.fl[0] = r[15];
        end
        return e;
    endfunction

    // Scoreboard: pushes model predictions on accept, pops on each delivered result.
    exp_t     sbq[$];
    exp_t     mon_e;
    logic [2:0] mf;
    logic     sb_en = 1'b0;
    logic     prev_stall = 1'b0;
    logic [15:0] prev_res;
    logic     prev_ill;

    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if (prev_stall) begin
                check("hold_valid", i16.out_valid, 1);
                check("hold_result", i16.result, prev_res);
                check("hold_illegal", i16.illegal, prev_ill);
            end
            if (i16.out_valid && i16.out_ready) begin
                if (sbq.size() == 0) begin
                    check("sb_unexpected_output", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("sb_result", i16.result, mon_e.res);
                    check("sb_illegal", i16.illegal, mon_e.ill);
                    check("sb_flags", i16.flags, mon_e.fl);
                end
            end
            if (i16.in_valid && i16.in_ready) begin
                mon_e = model(i16.op, i16.a, i16.b, mf);
                mf = mon_e.fl;
                sbq.push_back(mon_e);
            end
            prev_stall = i16.out_valid && !i16.out_ready;
            prev_res   = i16.result;
            prev_ill   = i16.illegal;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Each run task starts just after a rising edge; lat counts edges from the accept edge to out_valid.
    task automatic run16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output logic ill, output logic [2:0] fl, output int lat);
        i16.op = op; i16.a = a; i16.b = b; i16.in_valid = 1'b1;
        @(posedge clk); #1;
        i16.in_valid = 1'b0;
        lat = 1;
        while (!i16.out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        res = i16.result; ill = i16.illegal; fl = i16.flags;
    endtask

    task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ill, output logic [2:0] fl, output int lat);
        i32.op = op; i32.a = a; i32.b = b; i32.in_valid = 1'b1;
        @(posedge clk); #1;
        i32.in_valid = 1'b0;
        lat = 1;
        while (!i32.out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        res = i32.result; ill = i32.illegal; fl = i32.flags;
    endtask

    vec16_t tab16[23];
    vec32_t tab32[5];

    initial begin
        logic [15:0] r16;
        logic [31:0] r32;
        logic        ill;
        logic [2:0]  fl;
        int          lat;
        int          guard;

        // Expected flags are the cumulative {Z,V,N} after each row, starting from reset.
        tab16[0]  = '{4'h0, 16'h7FFF, 16'h0123, 16'h7FFF, 1'b0, 3'b010};
        tab16[1]  = '{4'h7, 16'hAB70, 16'h572F, 16'hF27F, 1'b0, 3'b010};
        tab16[2]  = '{4'h6, 16'h82AB, 16'h2F2A, 16'hAAE0, 1'b0, 3'b010};
        tab16[3]  = '{4'h5, 16'h8210, 16'h0028, 16'hFF82, 1'b0, 3'b010};
        tab16[4]  = '{4'h1, 16'h8000, 16'h0001, 16'h8000, 1'b0, 3'b011};
        tab16[5]  = '{4'hC, 16'h1234, 16'h5678, 16'h0000, 1'b1, 3'b011};
        tab16[6]  = '{4'h2, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 3'b111};
        tab16[7]  = '{4'h3, 16'h1111, 16'h2222, 16'h0000, 1'b1, 3'b111};
        tab16[8]  = '{4'h4, 16'h0001, 16'h0004, 16'h0010, 1'b0, 3'b011};
        tab16[9]  = '{4'h8, 16'h1235, 16'h0010, 16'h1244, 1'b0, 3'b011};
        tab16[10] = '{4'h9, 16'hFFFF, 16'h0002, 16'h0000, 1'b0, 3'b011};
        tab16[11] = '{4'hA, 16'h1234, 16'hABCD, 16'h12CD, 1'b0, 3'b011};
        tab16[12] = '{4'hB, 16'h1234, 16'h00AB, 16'hAB34, 1'b0, 3'b011};
        tab16[13] = '{4'h0, 16'h1234, 16'hEDCC, 16'h0000, 1'b0, 3'b100};
        tab16[14] = '{4'h1, 16'h1234, 16'h0123, 16'h1111, 1'b0, 3'b000};
        tab16[15] = '{4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 3'b000};
        tab16[16] = '{4'h7, 16'h8888, 16'h8888, 16'h8888, 1'b0, 3'b000};
        tab16[17] = '{4'h6, 16'h1234, 16'h0010, 16'h1234, 1'b0, 3'b000};
        tab16[18] = '{4'h0, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 3'b011};
        tab16[19] = '{4'h5, 16'h7FFF, 16'h000F, 16'h0000, 1'b0, 3'b111};
        tab16[20] = '{4'h4, 16'h8001, 16'h0011, 16'h0002, 1'b0, 3'b011};
        tab16[21] = '{4'h1, 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b0, 3'b010};
        tab16[22] = '{4'hD, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3'b010};

        tab32[0] = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b0, 3'b010};
        tab32[1] = '{4'hA, 32'h12345678, 32'h000000AB, 32'h123456AB, 1'b0, 3'b010};
        tab32[2] = '{4'h7, 32'h7F800102, 32'h01807F01, 32'h7F807F03, 1'b0, 3'b010};
        tab32[3] = '{4'h6, 32'h00000001, 32'h00000021, 32'h80000000, 1'b0, 3'b010};
        tab32[4] = '{4'h1, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0, 3'b011};

        rst = 1'b1;
        i16.in_valid = 1'b0; i16.out_ready = 1'b1; i16.op = 4'h0; i16.a = '0; i16.b = '0;
        i32.in_valid = 1'b0; i32.out_ready = 1'b1; i32.op = 4'h0; i32.a = '0; i32.b = '0;
        mf = 3'b000;

        // Reset values must appear before any clock edge.
        #2;
        check("rst_out_valid", i16.out_valid, 0);
        check("rst_result", i16.result, 0);
        check("rst_illegal", i16.illegal, 0);
        check("rst_flags", i16.flags, 0);
        check("rst_in_ready", i16.in_ready, 1);
        check("rst_out_valid32", i32.out_valid, 0);
        check("rst_in_ready32", i32.in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            run16(tab16[i].op, tab16[i].a, tab16[i].b, r16, ill, fl, lat);
            check($sformatf("t16[%0d]_latency", i), lat, 2);
            check($sformatf("t16[%0d]_result", i), r16, tab16[i].res);
            check($sformatf("t16[%0d]_illegal", i), ill, tab16[i].ill);
            check($sformatf("t16[%0d]_flags", i), fl, tab16[i].fl);
        end

        for (int i = 0; i < 5; i++) begin
            run32(tab32[i].op, tab32[i].a, tab32[i].b, r32, ill, fl, lat);
            check($sformatf("t32[%0d]_latency", i), lat, 2);
            check($sformatf("t32[%0d]_result", i), r32, tab32[i].res);
            check($sformatf("t32[%0d]_illegal", i), ill, tab32[i].ill);
            check($sformatf("t32[%0d]_flags", i), fl, tab32[i].fl);
        end

        // Fill both stages under stall, then reset between clock edges.
        @(posedge clk); #1;
        i16.out_ready = 1'b0;
        i16.op = 4'h0; i16.a = 16'h8000; i16.b = 16'hFFFF; i16.in_valid = 1'b1;
        @(posedge clk); #1;
        i16.a = 16'h0001; i16.b = 16'h0001;
        @(posedge clk); #1;
        i16.in_valid = 1'b0;
        check("prerst_out_valid", i16.out_valid, 1);
        check("prerst_flags", i16.flags, 3'b011);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", i16.out_valid, 0);
        check("midrst_flags", i16.flags, 0);
        check("midrst_result", i16.result, 0);
        check("midrst_in_ready", i16.in_ready, 1);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("postrst_no_stale", i16.out_valid, 0);
        i16.out_ready = 1'b1;
        run16(4'h1, 16'h1234, 16'h0123, r16, ill, fl, lat);
        check("postrst_latency", lat, 2);
        check("postrst_result", r16, 16'h1111);
        check("postrst_flags", fl, 3'b000);

        // Clean restart so the scoreboard's flag model starts from zero.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mf = 3'b000;
        sbq.delete();
        sb_en = 1'b1;

        // Back-to-back ADD, XOR, LHB into a stalled output.
        i16.out_ready = 1'b0;
        i16.op = 4'h0; i16.a = 16'h0005; i16.b = 16'h0003; i16.in_valid = 1'b1;
        @(posedge clk); #1;
        i16.op = 4'h2; i16.a = 16'h00F0; i16.b = 16'h0F0F;
        @(posedge clk); #1;
        i16.op = 4'hB; i16.a = 16'h1234; i16.b = 16'h00AB;
        check("stall_in_ready", i16.in_ready, 0);
        check("stall_out_valid", i16.out_valid, 1);
        check("stall_result", i16.result, 16'h0008);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("stall_hold%0d_result", k), i16.result, 16'h0008);
            check($sformatf("stall_hold%0d_in_ready", k), i16.in_ready, 0);
        end
        i16.out_ready = 1'b1;
        @(posedge clk); #1;
        i16.in_valid = 1'b0;
        check("drain_xor", i16.result, 16'h0FFF);
        @(posedge clk); #1;
        check("drain_lhb", i16.result, 16'hAB34);
        check("drain_lhb_valid", i16.out_valid, 1);
        @(posedge clk); #1;
        check("drain_bubble", i16.out_valid, 0);

        // Random traffic with random backpressure.
        for (int c = 0; c < 800; c++) begin
            i16.in_valid  = ($urandom_range(0, 3) != 0);
            i16.out_ready = ($urandom_range(0, 3) != 0);
            i16.op        = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       i16.a = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
                default: i16.a = 16'($urandom);
            endcase
            i16.b = 16'($urandom);
            @(posedge clk); #1;
        end
        i16.in_valid  = 1'b0;
        i16.out_ready = 1'b1;
        guard = 0;
        while (sbq.size() != 0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("final_queue_empty", sbq.size(), 0);
        sb_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning datapath width in bits; legal values are multiples of 8, 16 or more.
REQ-002 The block SHALL have parameter LANE, default 4, meaning PADDSB lane width in bits; it must divide WIDTH.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid  input  1  operation present.
REQ-006 The block SHALL have port in_ready  output  1  operation accepted when high together with in_valid.
REQ-007 The block SHALL have ports a and b, each input, WIDTH bits, meaning the operands.
REQ-008 The block SHALL have port op  input  4  opcode as listed in REQ-013.
REQ-009 The block SHALL have port out_valid  output  1  result present.
REQ-010 The block SHALL have port out_ready  input  1  consumer takes the result when high together with out_valid.
REQ-011 The block SHALL have ports result (output, WIDTH bits) and illegal (output, 1 bit, undefined opcode flagged).
REQ-012 The block SHALL have port flags  output  3  registered {Z,V,N}.

Function
REQ-013 Opcodes SHALL be as follows.
- 0000 ADD, saturating signed; 0001 SUB, saturating signed; 0010 XOR.
- 0100 SLL, 0101 SRA, 0110 ROR; shift amount = b[$clog2(WIDTH)-1:0].
- 0111 PADDSB: independent signed saturating add per LANE-bit lane.
- 1000 LW and 1001 SW: (a & ~1) + b, wrapping, no saturation.
- 1010 LLB: {a[WIDTH-1:8], b[7:0]}; 1011 LHB: {b[7:0], a[WIDTH-9:0]}.
REQ-014 Saturation SHALL clamp to 0x7F..F on positive overflow and to 0x80..0 on negative overflow; each PADDSB lane SHALL clamp to its own LANE-bit limits.
REQ-015 Opcodes 0011 and 11xx SHALL give result 0 and illegal=1, and SHALL NOT update flags.
REQ-016 The pipeline SHALL have two register stages: S1 captures the operands and opcode on accept; S2 captures the computed result.
- Latency from accept edge to out_valid high: 2 cycles.
- Throughput: 1 operation per cycle when out_ready is held high.
REQ-017 Ready logic SHALL be as follows.
- S2 advances when out_ready=1 or S2 is empty.
- S1 advances when S2 advances or S1 is empty.
- in_ready equals the S1-advance condition; the out_ready-to-in_ready path is combinational.
REQ-018 While out_valid=1 and out_ready=0, result, illegal and out_valid SHALL hold stable.
REQ-019 Operations SHALL emerge in acceptance order with none dropped or duplicated.
REQ-020 The flags register SHALL update on the edge a result is loaded into S2.
- ADD/SUB: update Z, V, N, where V = overflow occurred and Z/N are taken from the saturated result.
- XOR, SLL, SRA, ROR: update Z only; V and N hold.
- All other opcodes: flags hold.
REQ-021 A bubble (S1 empty when S2 advances) SHALL clear out_valid and leave flags unchanged.

Reset
REQ-022 While rst=1, the block SHALL clear S1/S2 valid, result, illegal and flags to 0 asynchronously; in_ready SHALL be 1.
REQ-023 Asserting rst mid-operation SHALL discard all in-flight operations; the first operation accepted after release SHALL again have 2-cycle latency.

Structure
REQ-024 Package alu_pkg SHALL hold the opcode enum, the flag bit indices (Z=2, V=1, N=0) and the illegal-opcode helper function.
REQ-025 The combinational datapath SHALL be sub-module alu_core, parameterised by WIDTH and LANE, with outputs result, illegal, z, v, n and per-flag update enables; alu_pipe adds the stages, handshake and flags register.

Verification
REQ-026 WIDTH=16: ADD a=7FFF, b=0123 -> result 7FFF, flags V=1 N=0 Z=0, out_valid exactly 2 cycles after accept.
REQ-027 WIDTH=16: PADDSB AB70+572F -> F27F; ROR 82AB with b=2F2A -> AAE0; SRA 8210 with b=0028 -> FF82; none of these change V or N.
REQ-028 Back-to-back ADD, XOR, LHB with out_ready=0 for 4 cycles -> in_ready falls once both stages are full; after out_ready rises, results appear in order, each held stable while stalled.
REQ-029 op=1100 -> result 0000, illegal=1; a following XOR FFFF^FFFF -> 0000 with Z=1 and V/N unchanged from before.
REQ-030 rst pulse with both stages valid -> out_valid=0 and flags=000 with no clock edge required; the next accepted SUB 1234-0123 -> 1111 after 2 cycles.
REQ-031 WIDTH=32: ADD 7FFFFFFF+00000001 -> 7FFFFFFF with V=1; LLB a=12345678, b=000000AB -> 123456AB.
